// File: rtl/spi_fifo_pkg.sv
// Shared types and constants for the SPI byte-buffering sequencer.
package spi_fifo_pkg;

  localparam int unsigned SPI_BYTE_W          = 8;
  localparam int unsigned SPI_FIFO_DEPTH_LOG2 = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_DRAIN
  } seq_state_e;

endpackage

// File: rtl/spi_fifo_sequencer_if.sv
// Register-block and frontend signals of the SPI FIFO sequencer, named from the sequencer's view.
interface spi_fifo_sequencer_if
  import spi_fifo_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = SPI_FIFO_DEPTH_LOG2
);
  localparam int unsigned LVL_W = DEPTH_LOG2 + 1;

  logic                  flush_i;
  logic                  tx_push_i;
  logic [SPI_BYTE_W-1:0] tx_data_i;
  logic                  tx_full_o;
  logic                  tx_empty_o;
  logic [LVL_W-1:0]      tx_level_o;
  logic                  rx_pop_i;
  logic [SPI_BYTE_W-1:0] rx_data_o;
  logic                  rx_empty_o;
  logic                  rx_full_o;
  logic [LVL_W-1:0]      rx_level_o;
  logic                  rx_overrun_o;
  logic                  clear_overrun_i;
  logic                  busy_o;
  logic                  transmit_o;
  logic [SPI_BYTE_W-1:0] transmit_data_o;
  logic                  transmit_done_i;
  logic [SPI_BYTE_W-1:0] received_data_i;

  modport master (
    output flush_i, tx_push_i, tx_data_i, rx_pop_i, clear_overrun_i,
           transmit_done_i, received_data_i,
    input  tx_full_o, tx_empty_o, tx_level_o, rx_data_o, rx_empty_o, rx_full_o,
           rx_level_o, rx_overrun_o, busy_o, transmit_o, transmit_data_o
  );

  modport slave (
    input  flush_i, tx_push_i, tx_data_i, rx_pop_i, clear_overrun_i,
           transmit_done_i, received_data_i,
    output tx_full_o, tx_empty_o, tx_level_o, rx_data_o, rx_empty_o, rx_full_o,
           rx_level_o, rx_overrun_o, busy_o, transmit_o, transmit_data_o
  );

endinterface

// File: rtl/spi_byte_fifo.sv
// Circular byte FIFO with flush and a force-pop input used to make room for a new byte.
module spi_byte_fifo
  import spi_fifo_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = SPI_FIFO_DEPTH_LOG2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  logic [SPI_BYTE_W-1:0] data_i,
  input  logic                  pop_i,
  input  logic                  force_pop_i,
  output logic [SPI_BYTE_W-1:0] data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_LOG2:0]   level_o
);
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

  logic [DEPTH_LOG2-1:0] wptr_q, rptr_q;
  logic [CNT_W-1:0]      count_q;
  logic [SPI_BYTE_W-1:0] mem_q [DEPTH];
  logic                  do_push_c, do_pop_c;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign level_o   = count_q;
  assign data_o    = empty_o ? '0 : mem_q[rptr_q];
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop_c  = (pop_i | force_pop_i) & ~empty_o;
  assign do_push_c = push_i & (~full_o | do_pop_c);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push_c) begin
        mem_q[wptr_q] <= data_i;
        wptr_q        <= wptr_q + DEPTH_LOG2'(1);
      end
      if (do_pop_c) rptr_q <= rptr_q + DEPTH_LOG2'(1);
      case ({do_push_c, do_pop_c})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/spi_fifo_sequencer.sv
// Buffers TX/RX bytes between the SPI register block and spi_frontend, launching one transfer per byte.
// Define SPI_FIFO_RX_OVERWRITE_EN to replace the oldest RX byte on overrun instead of dropping the newest.
module spi_fifo_sequencer
  import spi_fifo_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = SPI_FIFO_DEPTH_LOG2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  spi_fifo_sequencer_if.slave bus
);
  seq_state_e            state_q, state_d;
  logic                  tx_pop_c, rx_push_c, rx_drop_c, rx_force_pop_c;
  logic [SPI_BYTE_W-1:0] tx_head;
  logic [SPI_BYTE_W-1:0] tx_data_q;
  logic                  transmit_q, overrun_q;

  spi_byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (bus.flush_i),
    .push_i      (bus.tx_push_i),
    .data_i      (bus.tx_data_i),
    .pop_i       (tx_pop_c),
    .force_pop_i (1'b0),
    .data_o      (tx_head),
    .full_o      (bus.tx_full_o),
    .empty_o     (bus.tx_empty_o),
    .level_o     (bus.tx_level_o)
  );

  spi_byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (bus.flush_i),
    .push_i      (rx_push_c),
    .data_i      (bus.received_data_i),
    .pop_i       (bus.rx_pop_i),
    .force_pop_i (rx_force_pop_c),
    .data_o      (bus.rx_data_o),
    .full_o      (bus.rx_full_o),
    .empty_o     (bus.rx_empty_o),
    .level_o     (bus.rx_level_o)
  );

  // A received byte is lost (or displaces the oldest) only if software is not popping this cycle.
  assign rx_drop_c = rx_push_c & bus.rx_full_o & ~bus.rx_pop_i;
`ifdef SPI_FIFO_RX_OVERWRITE_EN
  assign rx_force_pop_c = rx_drop_c;
`else
  assign rx_force_pop_c = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next state plus the FIFO strobes that accompany each transition.
  always_comb begin
    state_d   = state_q;
    tx_pop_c  = 1'b0;
    rx_push_c = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!bus.tx_empty_o && !bus.flush_i) begin
          tx_pop_c = 1'b1;
          state_d  = ST_LAUNCH;
        end
      end
      ST_LAUNCH: state_d = ST_WAIT;
      ST_WAIT: begin
        if (bus.transmit_done_i) begin
          rx_push_c = 1'b1;
          state_d   = ST_IDLE;
        end else if (bus.flush_i) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (bus.transmit_done_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobe and byte register for the frontend; the byte holds until the next pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      transmit_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      transmit_q <= tx_pop_c;
      if (tx_pop_c) tx_data_q <= tx_head;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                  overrun_q <= 1'b0;
    else if (bus.flush_i)         overrun_q <= 1'b0;
    else if (rx_drop_c)           overrun_q <= 1'b1;
    else if (bus.clear_overrun_i) overrun_q <= 1'b0;
  end

  assign bus.transmit_o      = transmit_q;
  assign bus.transmit_data_o = tx_data_q;
  assign bus.rx_overrun_o    = overrun_q;
  assign bus.busy_o          = (state_q != ST_IDLE) | ~bus.tx_empty_o;

endmodule
